genc_denetleyici: RTL and testbench

GENC_DENETLEYICI -- requirements
Module: genc_denetleyici

---
 rtl/genc_denetleyici.sv | 162 ++++++++++++++++
 tb/tb_genc_denetleyici.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/genc_denetleyici.sv
// Instruction fetch/step controller. It fetches one instruction word from instruction memory
// at the core's pc and hands it to the core with a single-cycle advance enable. It supports
// continuous run and single-step modes, halt requests, fetch timeout and error reporting.
module genc_denetleyici #(
  // Maximum number of cycles GETIR waits for imem_valid before reporting a timeout
  parameter int unsigned ZAMAN_ASIMI = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        baslat,
  input  logic        adim,
  input  logic        durdur,
  input  logic        temizle,
  input  logic [31:0] core_pc,
  input  logic        core_hata,
  output logic        core_en,
  output logic [31:0] komut,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [1:0]  durum,
  output logic [1:0]  hata_kod,
  output logic [31:0] sayac
);

  // The encodings are visible on durum, so they are fixed explicitly
  typedef enum logic [1:0] {
    StBosta = 2'b00,
    StGetir = 2'b01,
    StYurut = 2'b10,
    StHata  = 2'b11
  } durum_e;

  localparam logic [31:0] KomutNop  = 32'h0000_0013;
  localparam logic [1:0]  HataYok   = 2'b00;
  localparam logic [1:0]  HataCore  = 2'b01;
  localparam logic [1:0]  HataHizal = 2'b10;
  localparam logic [1:0]  HataZaman = 2'b11;

  // One extra value of headroom keeps the width at least one bit for tiny limits
  localparam int unsigned ZamanW = $clog2(ZAMAN_ASIMI + 2);
  localparam logic [ZamanW-1:0] ZamanSinir = ZamanW'(ZAMAN_ASIMI);

  durum_e             durum_q;
  logic               adim_mod_q;   // 1: single-step mode, 0: continuous run
  logic               bekleyen_q;   // halt requested, stop after the current instruction
  logic               giris_q;      // first cycle of GETIR: sample pc, decide on the request
  logic [ZamanW-1:0]  zaman_q;
  logic               core_en_q;
  logic               imem_req_q;
  logic [31:0]        imem_addr_q;
  logic [31:0]        komut_q;
  logic [1:0]         hata_kod_q;
  logic [31:0]        sayac_q;

  logic [ZamanW-1:0]  zaman_art;
  logic               pc_hizasiz;
  logic               bitir;

  assign zaman_art  = zaman_q + ZamanW'(1);
  assign pc_hizasiz = (core_pc[1:0] != 2'b00);
  // Current-cycle durdur counts too, so a request seen in YURUT itself is honoured
  assign bitir      = adim_mod_q | bekleyen_q | durdur;

  // Controller FSM; every output is a register updated here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      durum_q     <= StBosta;
      adim_mod_q  <= 1'b0;
      bekleyen_q  <= 1'b0;
      giris_q     <= 1'b0;
      zaman_q     <= '0;
      core_en_q   <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      komut_q     <= KomutNop;
      hata_kod_q  <= HataYok;
      sayac_q     <= '0;
    end else begin
      // core_en is a one-cycle pulse, only re-armed on the GETIR -> YURUT transition
      core_en_q <= 1'b0;
      unique case (durum_q)
        StBosta: begin
          if (baslat || adim) begin
            // baslat wins when both are high
            adim_mod_q <= ~baslat;
            giris_q    <= 1'b1;
            durum_q    <= StGetir;
          end
        end

        StGetir: begin
          if (giris_q) begin
            giris_q    <= 1'b0;
            zaman_q    <= '0;
            bekleyen_q <= durdur;
            if (pc_hizasiz) begin
              hata_kod_q <= HataHizal;
              durum_q    <= StHata;
            end else begin
              imem_addr_q <= core_pc;
              imem_req_q  <= 1'b1;
            end
          end else begin
            if (durdur) begin
              bekleyen_q <= 1'b1;
            end
            if (imem_valid && imem_req_q) begin
              komut_q    <= imem_rdata;
              imem_req_q <= 1'b0;
              core_en_q  <= 1'b1;
              durum_q    <= StYurut;
            end else if (zaman_art == ZamanSinir) begin
              zaman_q    <= zaman_art;
              imem_req_q <= 1'b0;
              hata_kod_q <= HataZaman;
              durum_q    <= StHata;
            end else begin
              zaman_q <= zaman_art;
            end
          end
        end

        StYurut: begin
          // The instruction retires even when the core flags an error on it
          sayac_q <= sayac_q + 32'd1;
          if (core_hata) begin
            hata_kod_q <= HataCore;
            durum_q    <= StHata;
          end else if (bitir) begin
            bekleyen_q <= 1'b0;
            durum_q    <= StBosta;
          end else begin
            giris_q <= 1'b1;
            durum_q <= StGetir;
          end
        end

        StHata: begin
          if (temizle) begin
            hata_kod_q <= HataYok;
            durum_q    <= StBosta;
          end
        end

        default: begin
          durum_q <= StBosta;
        end
      endcase
    end
  end

  assign core_en   = core_en_q;
  assign komut     = komut_q;
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign durum     = durum_q;
  assign hata_kod  = hata_kod_q;
  assign sayac     = sayac_q;

endmodule

// File: tb/tb_genc_denetleyici.sv
// Bench for genc_denetleyici: a small core model advances pc on core_en, a memory model answers
// requests one cycle later, and fetched words are queued and checked when the core consumes them.
module tb_genc_denetleyici;

  logic        clk;
  logic        reset;
  logic        baslat;
  logic        adim;
  logic        durdur;
  logic        temizle;
  logic [31:0] core_pc;
  logic        core_hata;
  logic        core_en;
  logic [31:0] komut;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [1:0]  durum;
  logic [1:0]  hata_kod;
  logic [31:0] sayac;

  int n_karsilastirma;
  int n_uyusmazlik;
  int darbe_sayisi;
  int istek_sayisi;
  logic mem_acik;
  logic hata_enjekte;
  logic [31:0] beklenen_q[$];

  genc_denetleyici #(
    .ZAMAN_ASIMI(16)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .baslat    (baslat),
    .adim      (adim),
    .durdur    (durdur),
    .temizle   (temizle),
    .core_pc   (core_pc),
    .core_hata (core_hata),
    .core_en   (core_en),
    .komut     (komut),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .durum     (durum),
    .hata_kod  (hata_kod),
    .sayac     (sayac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_karsilastirma++;
    if (gozlenen !== beklenen) begin
      n_uyusmazlik++;
      $display("FAIL %s: gozlenen=%08h beklenen=%08h (t=%0t)", etiket, gozlenen, beklenen,
               $time);
    end
  endtask

  function automatic logic [31:0] mem_oku(input logic [31:0] adr);
    if (adr == 32'h0) return 32'h0050_0093;
    return {adr[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  // One clock: apply the core and memory models around the edge, consume scoreboard entries
  task automatic tik();
    logic ce_once;
    logic istek_once;
    logic [31:0] beklenen;
    ce_once    = core_en;
    istek_once = imem_req && !imem_valid;
    @(posedge clk);
    #1;
    if (ce_once) core_pc = core_pc + 32'd4;
    imem_valid = mem_acik && istek_once;
    if (imem_valid) begin
      kontrol("imem_addr", imem_addr, core_pc);
      imem_rdata = mem_oku(imem_addr);
      beklenen_q.push_back(imem_rdata);
    end
    if (imem_req) istek_sayisi++;
    if (core_en) begin
      darbe_sayisi++;
      if (beklenen_q.size() == 0) begin
        kontrol("kuyruk_dolu", 32'(beklenen_q.size()), 32'd1);
      end else begin
        beklenen = beklenen_q.pop_front();
        kontrol("komut", komut, beklenen);
      end
    end
    core_hata = hata_enjekte & core_en;
    kontrol("core_en_ardisik", {31'b0, core_en & ce_once}, 32'd0);
    if (durum != 2'b10) kontrol("core_en_yurut_disi", {31'b0, core_en}, 32'd0);
  endtask

  task automatic durum_bekle(input string etiket, input logic [1:0] hedef, input int sinir);
    int i;
    i = 0;
    while (durum != hedef && i < sinir) begin
      tik();
      i++;
    end
    kontrol(etiket, {30'b0, durum}, {30'b0, hedef});
  endtask

  task automatic darbe_bekle(input int hedef, input int sinir);
    int i;
    i = 0;
    while (darbe_sayisi < hedef && i < sinir) begin
      tik();
      i++;
    end
    kontrol("darbe_bekle", darbe_sayisi, hedef);
  endtask

  task automatic sifirla();
    reset = 1'b0;
    baslat = 1'b0; adim = 1'b0; durdur = 1'b0; temizle = 1'b0;
    imem_valid = 1'b0; imem_rdata = '0; core_hata = 1'b0;
    hata_enjekte = 1'b0; mem_acik = 1'b1; core_pc = '0;
    beklenen_q.delete();
    tik();
    tik();
    reset = 1'b1;
    tik();
    darbe_sayisi = 0;
    istek_sayisi = 0;
  endtask

  task automatic sifir_degerleri(input string on);
    kontrol({on, "_durum"}, {30'b0, durum}, 32'd0);
    kontrol({on, "_core_en"}, {31'b0, core_en}, 32'd0);
    kontrol({on, "_imem_req"}, {31'b0, imem_req}, 32'd0);
    kontrol({on, "_imem_addr"}, imem_addr, 32'd0);
    kontrol({on, "_komut"}, komut, 32'h0000_0013);
    kontrol({on, "_hata_kod"}, {30'b0, hata_kod}, 32'd0);
    kontrol({on, "_sayac"}, sayac, 32'd0);
  endtask

  initial begin
    n_karsilastirma = 0;
    n_uyusmazlik = 0;
    darbe_sayisi = 0;
    istek_sayisi = 0;

    // Reset values
    sifirla();
    sifir_degerleri("reset");

    // Single step at pc 0
    adim = 1'b1;
    tik();
    adim = 1'b0;
    durum_bekle("adim_bosta", 2'b00, 20);
    kontrol("adim_komut", komut, 32'h0050_0093);
    kontrol("adim_darbe", darbe_sayisi, 32'd1);
    kontrol("adim_sayac", sayac, 32'd1);
    kontrol("adim_kuyruk", 32'(beklenen_q.size()), 32'd0);

    // Continuous run, halted during the third fetch
    sifirla();
    baslat = 1'b1;
    tik();
    baslat = 1'b0;
    darbe_bekle(2, 40);
    durum_bekle("kosu_getir3", 2'b01, 5);
    durdur = 1'b1;
    tik();
    durdur = 1'b0;
    durum_bekle("kosu_bosta", 2'b00, 40);
    kontrol("kosu_darbe", darbe_sayisi, 32'd3);
    kontrol("kosu_sayac", sayac, 32'd3);
    kontrol("kosu_pc", core_pc, 32'hC);
    tik();
    tik();
    kontrol("kosu_durgun", {30'b0, durum}, 32'd0);

    // Fetch timeout
    sifirla();
    mem_acik = 1'b0;
    baslat = 1'b1;
    tik();
    baslat = 1'b0;
    durum_bekle("zaman_hata", 2'b11, 40);
    kontrol("zaman_istek", istek_sayisi, 32'd16);
    kontrol("zaman_kod", {30'b0, hata_kod}, 32'd3);
    kontrol("zaman_req_dusuk", {31'b0, imem_req}, 32'd0);
    tik();
    kontrol("zaman_hata_tut", {30'b0, durum}, 32'd3);
    temizle = 1'b1;
    tik();
    temizle = 1'b0;
    kontrol("temizle_durum", {30'b0, durum}, 32'd0);
    kontrol("temizle_kod", {30'b0, hata_kod}, 32'd0);

    // Misaligned pc
    sifirla();
    core_pc = 32'h2;
    adim = 1'b1;
    tik();
    adim = 1'b0;
    durum_bekle("hizasiz_hata", 2'b11, 10);
    kontrol("hizasiz_kod", {30'b0, hata_kod}, 32'd2);
    kontrol("hizasiz_istek", istek_sayisi, 32'd0);
    baslat = 1'b1;
    adim = 1'b1;
    tik();
    baslat = 1'b0;
    adim = 1'b0;
    tik();
    kontrol("hata_baslat_yoksay", {30'b0, durum}, 32'd3);
    temizle = 1'b1;
    tik();
    temizle = 1'b0;

    // Core error on an aligned fetch
    sifirla();
    core_pc = 32'h10;
    hata_enjekte = 1'b1;
    adim = 1'b1;
    tik();
    adim = 1'b0;
    durum_bekle("core_hata", 2'b11, 20);
    hata_enjekte = 1'b0;
    core_hata = 1'b0;
    kontrol("core_hata_kod", {30'b0, hata_kod}, 32'd1);
    kontrol("core_hata_sayac", sayac, 32'd1);
    tik();
    kontrol("core_hata_sayac_tut", sayac, 32'd1);
    temizle = 1'b1;
    tik();
    temizle = 1'b0;
    kontrol("core_temizle", {30'b0, hata_kod}, 32'd0);

    // Reset while a fetch is outstanding
    sifirla();
    baslat = 1'b1;
    tik();
    baslat = 1'b0;
    darbe_bekle(5, 80);
    tik();
    tik();
    kontrol("orta_durum", {30'b0, durum}, 32'd1);
    kontrol("orta_sayac", sayac, 32'd5);
    kontrol("orta_req", {31'b0, imem_req}, 32'd1);
    kontrol("orta_addr", imem_addr, 32'h14);
    #2;
    reset = 1'b0;
    imem_valid = 1'b0;
    #1;
    sifir_degerleri("orta_reset");
    beklenen_q.delete();
    tik();
    reset = 1'b1;
    tik();
    kontrol("birak_durum", {30'b0, durum}, 32'd0);
    kontrol("birak_sayac", sayac, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsilastirma, n_uyusmazlik);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_sure: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
